// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared types and widths for the accumulator-ALU request arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int ALU_DATA_W = 16;
  localparam int ALU_OP_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [ALU_OP_W-1:0]   op;
    logic [ALU_DATA_W-1:0] data;
    logic                  push;
    logic                  pop;
    logic                  lock;
  } alu_req_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin search from ptr upward, wrapping modulo N_REQ.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [N_REQ-1:0] w_elig;
  int               w_idx;

  assign w_elig = req & mask;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    w_idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= N_REQ) begin
        w_idx = w_idx - N_REQ;
      end
      if (!grant_any && w_elig[w_idx[PTR_W-1:0]]) begin
        grant_any                 = 1'b1;
        grant[w_idx[PTR_W-1:0]]   = 1'b1;
        grant_idx                 = w_idx[PTR_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_req_arbiter.sv
// ============================================================================
// Module : alu_req_arbiter
// Brief  : Round-robin sharing of one accumulator ALU between N_REQ requesters,
//          with per-requester lock for multi-op sequences and a synchronous flush.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = ALU_DATA_W,
  parameter int OP_W    = ALU_OP_W,
  parameter int ALU_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*OP_W-1:0]   req_op,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]    req_push,
  input  logic [N_REQ-1:0]    req_pop,
  input  logic [N_REQ-1:0]    req_lock,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_zero,
  output logic                alu_ce,
  output logic [OP_W-1:0]     alu_op,
  output logic [DATA_W-1:0]   alu_data_in,
  output logic                alu_push,
  output logic                alu_pop,
  output logic                alu_clr,
  input  logic [DATA_W-1:0]   alu_data_out,
  input  logic                alu_zero
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(ALU_LAT + 1);

  arb_state_t         r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic               r_lock_vld;
  logic [PTR_W-1:0]   r_lock_owner;
  logic [PTR_W-1:0]   r_win;
  logic [OP_W-1:0]    r_op;
  logic [DATA_W-1:0]  r_data;
  logic               r_push;
  logic               r_pop;
  logic               r_lock;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_REQ-1:0]   r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;
  logic               r_rsp_zero;
  logic               r_alu_clr;

  logic               w_owner_req;
  logic               w_lock_hold;
  logic [N_REQ-1:0]   w_mask;
  logic [N_REQ-1:0]   w_grant;
  logic [PTR_W-1:0]   w_grant_idx;
  logic               w_grant_any;
  logic               w_accept;
  logic               w_issue;

  // A live lock narrows eligibility to the owner; a dropped owner valid frees everyone this cycle.
  assign w_owner_req = req_valid[r_lock_owner];
  assign w_lock_hold = r_lock_vld && w_owner_req;
  assign w_mask      = w_lock_hold ? ({{(N_REQ-1){1'b0}}, 1'b1} << r_lock_owner) : '1;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (r_rr_ptr),
    .mask      (w_mask),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .grant_any (w_grant_any)
  );

  assign w_accept  = reset && !clr && (r_state == IDLE) && w_grant_any;
  assign req_ready = w_accept ? w_grant : '0;

  assign w_issue     = (r_state == ISSUE);
  assign alu_ce      = w_issue;
  assign alu_op      = w_issue ? r_op   : '0;
  assign alu_data_in = w_issue ? r_data : '0;
  assign alu_push    = w_issue && r_push;
  assign alu_pop     = w_issue && r_pop;
  assign alu_clr     = r_alu_clr;

  // A flush in the RESP cycle suppresses the already-registered pulse.
  assign rsp_valid = clr ? '0 : r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_zero  = r_rsp_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_lock_vld   <= 1'b0;
      r_lock_owner <= '0;
      r_win        <= '0;
      r_op         <= '0;
      r_data       <= '0;
      r_push       <= 1'b0;
      r_pop        <= 1'b0;
      r_lock       <= 1'b0;
      r_cnt        <= '0;
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_rsp_zero   <= 1'b0;
      r_alu_clr    <= 1'b0;
    end else begin
      r_alu_clr   <= clr;
      r_rsp_valid <= '0;
      if (clr) begin
        r_state    <= IDLE;
        r_lock_vld <= 1'b0;
        r_cnt      <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (r_lock_vld && !w_owner_req) begin
              r_lock_vld <= 1'b0;
            end
            if (w_grant_any) begin
              r_win   <= w_grant_idx;
              r_op    <= req_op[w_grant_idx*OP_W +: OP_W];
              r_data  <= req_data[w_grant_idx*DATA_W +: DATA_W];
              r_push  <= req_push[w_grant_idx];
              r_pop   <= req_pop[w_grant_idx];
              r_lock  <= req_lock[w_grant_idx];
              r_state <= ISSUE;
            end
          end
          ISSUE: begin
            r_cnt   <= CNT_W'(1);
            r_state <= WAIT;
          end
          WAIT: begin
            if (r_cnt == CNT_W'(ALU_LAT)) begin
              r_rsp_data  <= alu_data_out;
              r_rsp_zero  <= alu_zero;
              r_rsp_valid <= {{(N_REQ-1){1'b0}}, 1'b1} << r_win;
              r_cnt       <= '0;
              r_state     <= RESP;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          RESP: begin
            r_rr_ptr     <= (r_win == PTR_W'(N_REQ - 1)) ? '0 : r_win + PTR_W'(1);
            r_lock_vld   <= r_lock;
            r_lock_owner <= r_win;
            r_state      <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
// ============================================================================
// Module : tb_alu_req_arbiter
// Brief  : Scoreboard bench for alu_req_arbiter with a latency-accurate ALU model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_req_arbiter;

  localparam int N   = 2;
  localparam int DW  = 16;
  localparam int OW  = 8;
  localparam int LAT = 3;

  typedef struct packed {
    logic [OW-1:0] op;
    logic [DW-1:0] data;
    logic          push;
    logic          pop;
    logic          lock;
  } rq_t;

  typedef struct {
    int            cyc;
    logic [OW-1:0] op;
    logic [DW-1:0] d;
    logic          push;
    logic          pop;
  } iss_e_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] d;
    logic          z;
    int            cyc;
  } rsp_e_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             clr;
  logic [N-1:0]     req_valid, req_ready, req_push, req_pop, req_lock, rsp_valid;
  logic [N*OW-1:0]  req_op;
  logic [N*DW-1:0]  req_data;
  logic [DW-1:0]    rsp_data, alu_data_in, alu_data_out;
  logic             rsp_zero, alu_ce, alu_push, alu_pop, alu_clr, alu_zero;
  logic [OW-1:0]    alu_op;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  rq_t    q0[$];
  rq_t    q1[$];
  iss_e_t exp_iss[$];
  rsp_e_t exp_rsp[$];
  int     grant_log[$];
  int     acc_cyc_log[$];

  alu_req_arbiter #(.N_REQ(N), .DATA_W(DW), .OP_W(OW), .ALU_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .req_push(req_push), .req_pop(req_pop), .req_lock(req_lock),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .alu_ce(alu_ce), .alu_op(alu_op), .alu_data_in(alu_data_in),
    .alu_push(alu_push), .alu_pop(alu_pop), .alu_clr(alu_clr),
    .alu_data_out(alu_data_out), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] alu_fn(input logic [OW-1:0] op, input logic [DW-1:0] d);
    return d ^ {op ^ 8'h01, 8'h00};
  endfunction

  function automatic rq_t mk(input logic [OW-1:0] op, input logic [DW-1:0] d, input logic lock);
    rq_t r;
    r.op = op; r.data = d; r.push = op[0]; r.pop = op[1]; r.lock = lock;
    return r;
  endfunction

  // ALU model: result appears LAT cycles after the issue cycle; noise otherwise.
  logic [DW-1:0] pipe_d [LAT];
  logic          pipe_z [LAT];
  always @(posedge clk) begin
    for (int s = LAT - 1; s > 0; s--) begin
      pipe_d[s] <= pipe_d[s-1];
      pipe_z[s] <= pipe_z[s-1];
    end
    if (alu_ce) begin
      pipe_d[0] <= alu_fn(alu_op, alu_data_in);
      pipe_z[0] <= (alu_fn(alu_op, alu_data_in) == '0);
    end else begin
      pipe_d[0] <= DW'($urandom);
      pipe_z[0] <= 1'($urandom);
    end
  end
  assign alu_data_out = pipe_d[LAT-1];
  assign alu_zero     = pipe_z[LAT-1];

  task automatic drive_slot(input int i, input logic vld, input rq_t r);
    req_valid[i]            = vld;
    req_op[i*OW +: OW]      = vld ? r.op   : '0;
    req_data[i*DW +: DW]    = vld ? r.data : '0;
    req_push[i]             = vld && r.push;
    req_pop[i]              = vld && r.pop;
    req_lock[i]             = vld && r.lock;
  endtask

  // Requesters: hold the head of each queue until it is accepted.
  initial begin : drv
    logic [N-1:0] acc;
    rq_t          blank;
    blank = '0;
    req_valid = '0; req_op = '0; req_data = '0;
    req_push = '0; req_pop = '0; req_lock = '0;
    forever begin
      @(negedge clk);
      acc = req_ready & req_valid;
      @(posedge clk);
      #1;
      if (acc[0] && q0.size() > 0) void'(q0.pop_front());
      if (acc[1] && q1.size() > 0) void'(q1.pop_front());
      if (q0.size() > 0) drive_slot(0, 1'b1, q0[0]); else drive_slot(0, 1'b0, blank);
      if (q1.size() > 0) drive_slot(1, 1'b1, q1[0]); else drive_slot(1, 1'b0, blank);
    end
  end

  // Monitor and scoreboard.
  logic prev_clr = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      exp_iss.delete();
      exp_rsp.delete();
      prev_clr = 1'b0;
    end else begin
      if (alu_ce) begin
        if (exp_iss.size() == 0) chk("unexpected_alu_ce", 32'(alu_ce), 32'd0);
        else begin
          iss_e_t e;
          e = exp_iss.pop_front();
          chk("issue_cycle", 32'(cyc), 32'(e.cyc));
          chk("issue_op", 32'(alu_op), 32'(e.op));
          chk("issue_data", 32'(alu_data_in), 32'(e.d));
          chk("issue_push", 32'(alu_push), 32'(e.push));
          chk("issue_pop", 32'(alu_pop), 32'(e.pop));
        end
      end
      if (rsp_valid != '0) begin
        if (exp_rsp.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        else begin
          rsp_e_t e;
          e = exp_rsp.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
          chk("rsp_data", 32'(rsp_data), 32'(e.d));
          chk("rsp_zero", 32'(rsp_zero), 32'(e.z));
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      chk("alu_clr", 32'(alu_clr), 32'(prev_clr));
      if (clr) begin
        chk("ready_during_clr", 32'(req_ready), 32'd0);
        exp_iss.delete();
        exp_rsp.delete();
      end else if ((req_ready & req_valid) != '0) begin
        int w;
        iss_e_t ie;
        rsp_e_t re;
        chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        w = req_ready[1] ? 1 : 0;
        ie.cyc = cyc + 1; ie.op = req_op[w*OW +: OW]; ie.d = req_data[w*DW +: DW];
        ie.push = req_push[w]; ie.pop = req_pop[w];
        re.idx = w; re.d = alu_fn(ie.op, ie.d); re.z = (re.d == '0); re.cyc = cyc + LAT + 2;
        exp_iss.push_back(ie);
        exp_rsp.push_back(re);
        grant_log.push_back(w);
        acc_cyc_log.push_back(cyc);
      end
      prev_clr = clr;
    end
  end

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || exp_rsp.size() > 0) && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("idle_timeout", 32'(k >= budget), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_grants(input int n, input int budget);
    int k;
    k = 0;
    while (grant_log.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("grant_timeout", 32'(k >= budget), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    chk({tag, "_rsp_zero"}, 32'(rsp_zero), 32'd0);
    chk({tag, "_alu_ce"}, 32'(alu_ce), 32'd0);
    chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    chk({tag, "_alu_data"}, 32'(alu_data_in), 32'd0);
    chk({tag, "_alu_pushpop"}, 32'({alu_push, alu_pop}), 32'd0);
    chk({tag, "_alu_clr"}, 32'(alu_clr), 32'd0);
  endtask

  initial begin : scenario
    int base;
    int ta;
    int k;
    int exp_order[6];
    reset = 1'b0;
    clr   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Single request from requester 0.
    base = grant_log.size();
    q0.push_back(mk(8'h01, 16'h0005, 1'b0));
    wait_idle(100);
    chk("single_winner", 32'(grant_log[base]), 32'd0);
    chk("single_hold_data", 32'(rsp_data), 32'h0005);

    // Lock: requester 1 holds the ALU for three ops while requester 0 waits.
    base = grant_log.size();
    q1.push_back(mk(8'h02, 16'h1111, 1'b1));
    q1.push_back(mk(8'h03, 16'h2222, 1'b1));
    q1.push_back(mk(8'h04, 16'h3333, 1'b1));
    q0.push_back(mk(8'h05, 16'h4444, 1'b0));
    wait_idle(200);
    exp_order = '{1, 1, 1, 0, 0, 0};
    for (int i = 0; i < 4; i++) chk("lock_order", 32'(grant_log[base+i]), 32'(exp_order[i]));
    for (int i = 1; i < 4; i++)
      chk("lock_spacing", 32'(acc_cyc_log[base+i] - acc_cyc_log[base+i-1]), 32'(LAT + 3));

    // Contention without lock: strict alternation starting at requester 1.
    base = grant_log.size();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(8'h10 + 8'(i), 16'hA000 + 16'(i), 1'b0));
      q1.push_back(mk(8'h20 + 8'(i), 16'hB000 + 16'(i), 1'b0));
    end
    wait_idle(300);
    exp_order = '{1, 0, 1, 0, 1, 0};
    for (int i = 0; i < 6; i++) chk("rr_order", 32'(grant_log[base+i]), 32'(exp_order[i]));
    for (int i = 1; i < 6; i++)
      chk("rr_spacing", 32'(acc_cyc_log[base+i] - acc_cyc_log[base+i-1]), 32'(LAT + 3));

    // Zero result: flag and data are held after the pulse.
    q0.push_back(mk(8'h01, 16'h0000, 1'b0));
    wait_idle(100);
    repeat (3) @(posedge clk);
    chk("zero_hold_flag", 32'(rsp_zero), 32'd1);
    chk("zero_hold_data", 32'(rsp_data), 32'd0);

    // Flush during WAIT of a locked sequence.
    base = grant_log.size();
    q1.push_back(mk(8'h06, 16'h0600, 1'b1));
    q1.push_back(mk(8'h07, 16'h0700, 1'b1));
    wait_grants(base + 2, 100);
    ta = acc_cyc_log[base+1];
    k = 0;
    while (cyc != ta + 3 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("clr_align_timeout", 32'(k >= 50), 32'd0);
    clr = 1'b1;
    q0.push_back(mk(8'h08, 16'h0800, 1'b0));
    q1.push_back(mk(8'h09, 16'h0900, 1'b0));
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk("clr_pulse", 32'(alu_clr), 32'd1);
    wait_idle(200);
    chk("clr_next_winner", 32'(grant_log[base+2]), 32'd0);
    chk("clr_next_accept", 32'(acc_cyc_log[base+2]), 32'(ta + 4));
    chk("clr_then_other", 32'(grant_log[base+3]), 32'd1);

    // Reset asserted while the op is in ISSUE.
    base = grant_log.size();
    q0.push_back(mk(8'h0A, 16'h00AA, 1'b0));
    wait_grants(base + 1, 100);
    #1;
    chk("pre_reset_issue", 32'(alu_ce), 32'd1);
    reset = 1'b0;
    #1;
    check_outputs_zero("reset_mid_op");
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", 32'({req_ready, rsp_valid}), 32'd0);
    end
    base = grant_log.size();
    q1.push_back(mk(8'h0B, 16'h0B0B, 1'b0));
    wait_idle(100);
    chk("post_reset_winner", 32'(grant_log[base]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
